// File: rtl/divider_result_display.sv
// Display stage for the restoring divider: captures quotient/remainder on a
// rising valid, converts both to 5-digit BCD by a 16-step double-dabble, and
// scans them onto an 8-digit active-low multiplexed seven-segment display.
// Handshake: valid and toggle are levels from upstream; only their rising
// edges act. busy is high for the 16 conversion cycles and bcd_ready pulses
// for one cycle once the new digits sit in the display registers.
module divider_result_display #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [15:0] quotient,
  input  logic [15:0] remainder,
  input  logic        toggle,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        busy,
  output logic        bcd_ready
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_Q     = 7'b0011000;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state_q, state_d;
  logic        valid_dly_q, toggle_dly_q;
  logic        sel_q;
  logic [15:0] qbin_q, qbin_d, rbin_q, rbin_d;
  logic [19:0] qbcd_q, qbcd_d, rbcd_q, rbcd_d;
  logic [3:0]  iter_q, iter_d;
  logic [19:0] q_disp_q, q_disp_d, r_disp_q, r_disp_d;
  logic        ready_q, ready_d;
  logic [CNT_W-1:0] ref_cnt_q;
  logic [2:0]  idx_q;
  logic [6:0]  seg_q, seg_d;
  logic [7:0]  an_q;
  logic        valid_rise, toggle_rise;
  logic [19:0] disp_sel;

  // Add 3 to every BCD nibble that is 5 or more, before the shift.
  function automatic logic [19:0] add3(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low decimal segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = SEG_BLANK;
    endcase
  endfunction

  assign valid_rise = valid & ~valid_dly_q;
  assign toggle_rise = toggle & ~toggle_dly_q;
  assign busy = (state_q == CONV);
  assign bcd_ready = ready_q;
  assign seg = seg_q;
  assign an = an_q;
  assign disp_sel = sel_q ? r_disp_q : q_disp_q;

  // Capture/convert FSM: next state, double-dabble datapath and commit.
  always_comb begin
    state_d  = state_q;
    qbin_d   = qbin_q;
    rbin_d   = rbin_q;
    qbcd_d   = qbcd_q;
    rbcd_d   = rbcd_q;
    iter_d   = iter_q;
    q_disp_d = q_disp_q;
    r_disp_d = r_disp_q;
    ready_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_rise) begin
          state_d = CONV;
          qbin_d  = quotient;
          rbin_d  = remainder;
          qbcd_d  = '0;
          rbcd_d  = '0;
          iter_d  = '0;
        end
      end
      CONV: begin
        {qbcd_d, qbin_d} = {add3(qbcd_q), qbin_q} << 1;
        {rbcd_d, rbin_d} = {add3(rbcd_q), rbin_q} << 1;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          state_d  = IDLE;
          q_disp_d = qbcd_d;
          r_disp_d = rbcd_d;
          ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Segment pattern for the digit currently being scanned, with leading-zero blanking.
  always_comb begin
    seg_d = SEG_BLANK;
    case (idx_q)
      3'd0: seg_d = enc(disp_sel[3:0]);
      3'd1: if (disp_sel[19:4]  != '0) seg_d = enc(disp_sel[7:4]);
      3'd2: if (disp_sel[19:8]  != '0) seg_d = enc(disp_sel[11:8]);
      3'd3: if (disp_sel[19:12] != '0) seg_d = enc(disp_sel[15:12]);
      3'd4: if (disp_sel[19:16] != '0) seg_d = enc(disp_sel[19:16]);
      3'd7: seg_d = sel_q ? SEG_R : SEG_Q;
      default: seg_d = SEG_BLANK;
    endcase
  end

  // FSM, conversion and display registers plus input edge detectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_dly_q  <= 1'b0;
      toggle_dly_q <= 1'b0;
      sel_q        <= 1'b0;
      qbin_q       <= '0;
      rbin_q       <= '0;
      qbcd_q       <= '0;
      rbcd_q       <= '0;
      iter_q       <= '0;
      q_disp_q     <= '0;
      r_disp_q     <= '0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_dly_q  <= valid;
      toggle_dly_q <= toggle;
      if (toggle_rise) sel_q <= ~sel_q;
      qbin_q       <= qbin_d;
      rbin_q       <= rbin_d;
      qbcd_q       <= qbcd_d;
      rbcd_q       <= rbcd_d;
      iter_q       <= iter_d;
      q_disp_q     <= q_disp_d;
      r_disp_q     <= r_disp_d;
      ready_q      <= ready_d;
    end
  end

  // Refresh counter, digit index and registered anode/segment drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_q <= '0;
      idx_q     <= '0;
      seg_q     <= SEG_BLANK;
      an_q      <= 8'hFF;
    end else begin
      if (ref_cnt_q == CNT_MAX) begin
        ref_cnt_q <= '0;
        idx_q     <= idx_q + 3'd1;
      end else begin
        ref_cnt_q <= ref_cnt_q + CNT_ONE;
      end
      an_q  <= ~(8'b1 << idx_q);
      seg_q <= seg_d;
    end
  end

endmodule

// File: tb/tb_divider_result_display.sv
// Bench for divider_result_display with a 4-cycle refresh: directed scenarios,
// an arithmetic reference model compared every cycle, and literal digit checks.
module tb_divider_result_display;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] quotient = '0;
  logic [15:0] remainder = '0;
  logic        toggle = 1'b0;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        busy;
  logic        bcd_ready;

  int checks = 0;
  int errors = 0;
  int ready_seen = 0;

  divider_result_display #(.REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .valid(valid), .quotient(quotient),
    .remainder(remainder), .toggle(toggle), .seg(seg), .an(an),
    .busy(busy), .bcd_ready(bcd_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] enc(input int v);
    case (v)
      0: return 7'b1000000; 1: return 7'b1111001; 2: return 7'b0100100;
      3: return 7'b0110000; 4: return 7'b0011001; 5: return 7'b0010010;
      6: return 7'b0000010; 7: return 7'b1111000; 8: return 7'b0000000;
      9: return 7'b0010000; default: return 7'b1111111;
    endcase
  endfunction

  // Expected pattern of digit d when showing integer v (s: remainder view).
  function automatic logic [6:0] exp_digit(input int d, input int v, input bit s);
    int p;
    if (d == 7) return s ? 7'b0101111 : 7'b0011000;
    if (d == 5 || d == 6) return 7'b1111111;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (d > 0 && v < p) return 7'b1111111;
    return enc((v / p) % 10);
  endfunction

  // reference model + per-cycle scoreboard
  int m_q = 0, m_r = 0, m_pq = 0, m_pr = 0, m_rem = 0, m_ref = 0, m_idx = 0;
  bit m_sel = 0, m_vprev = 0, m_tprev = 0, m_ready = 0;
  logic [6:0] m_seg = 7'h7F;
  logic [7:0] m_an = 8'hFF;

  always @(posedge clk) begin
    bit vr, tr;
    if (rst) begin
      m_q = 0; m_r = 0; m_rem = 0; m_ref = 0; m_idx = 0;
      m_sel = 0; m_vprev = 0; m_tprev = 0; m_ready = 0;
      m_seg = 7'h7F; m_an = 8'hFF;
    end else begin
      m_seg = exp_digit(m_idx, m_sel ? m_r : m_q, m_sel);
      m_an = ~(8'b1 << m_idx);
      vr = valid && !m_vprev;
      tr = toggle && !m_tprev;
      m_ready = 0;
      if (m_rem == 0) begin
        if (vr) begin
          m_pq = int'(quotient); m_pr = int'(remainder); m_rem = 16;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_q = m_pq; m_r = m_pr; m_ready = 1;
        end
      end
      if (tr) m_sel = !m_sel;
      m_vprev = valid; m_tprev = toggle;
      if (m_ref == RD - 1) begin
        m_ref = 0; m_idx = (m_idx + 1) % 8;
      end else m_ref++;
    end
    #1;
    if (bcd_ready === 1'b1) ready_seen++;
    chk("busy", 32'(busy), 32'(m_rem != 0));
    chk("bcd_ready", 32'(bcd_ready), 32'(m_ready));
    chk("an", 32'(an), 32'(m_an));
    chk("seg", 32'(seg), 32'(m_seg));
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_valid(input int q, input int r, input int hold);
    @(negedge clk);
    quotient = 16'(q); remainder = 16'(r); valid = 1'b1;
    repeat (hold) @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic pulse_toggle();
    @(negedge clk); toggle = 1'b1;
    @(negedge clk); toggle = 1'b0;
    cycles(2);
  endtask

  // Wait (bounded) for digit d to be scanned, then compare its pattern.
  task automatic expect_digit(input string name, input int d, input logic [6:0] exp);
    bit found = 0;
    for (int i = 0; i < 8 * RD + 4 && !found; i++) begin
      @(negedge clk);
      if (an === ~(8'b1 << d)) found = 1;
    end
    if (!found) chk({name, "_scan"}, 32'(an), 32'(~(8'b1 << d)));
    else chk(name, 32'(seg), 32'(exp));
  endtask

  initial begin
    int base;
    // reset
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    rst = 1'b0;
    @(negedge clk);
    chk("first_an", 32'(an), 32'hFE);
    chk("first_seg", 32'(seg), 32'b1000000);
    expect_digit("idle_mode_q", 7, 7'b0011000);

    // basic 14 / 2
    base = ready_seen;
    pulse_valid(14, 2, 1);
    cycles(20);
    chk("basic_ready_cnt", 32'(ready_seen - base), 32'd1);
    expect_digit("basic_d0", 0, 7'b0011001);
    expect_digit("basic_d1", 1, 7'b1111001);
    expect_digit("basic_d2", 2, 7'b1111111);
    expect_digit("basic_d5", 5, 7'b1111111);

    // toggle to remainder and back
    pulse_toggle();
    expect_digit("tog_d0", 0, 7'b0100100);
    expect_digit("tog_d1", 1, 7'b1111111);
    expect_digit("tog_d7", 7, 7'b0101111);
    pulse_toggle();
    expect_digit("untog_d7", 7, 7'b0011000);

    // full range 65535 / 0
    pulse_valid(65535, 0, 1);
    cycles(20);
    expect_digit("full_d4", 4, 7'b0000010);
    expect_digit("full_d3", 3, 7'b0010010);
    pulse_toggle();
    expect_digit("full_r_d0", 0, 7'b1000000);
    expect_digit("full_r_d1", 1, 7'b1111111);
    pulse_toggle();

    // held valid: one capture
    base = ready_seen;
    pulse_valid(1234, 56, 40);
    cycles(2);
    chk("held_ready_cnt", 32'(ready_seen - base), 32'd1);
    expect_digit("held_d3", 3, 7'b1111001);

    // re-raise 5 cycles into CONV is ignored
    base = ready_seen;
    pulse_valid(321, 9, 1);
    cycles(4);
    pulse_valid(999, 888, 1);
    cycles(24);
    chk("reraise_ready_cnt", 32'(ready_seen - base), 32'd1);
    expect_digit("reraise_d2", 2, 7'b0110000);

    // valid rising on the last CONV step is ignored
    base = ready_seen;
    pulse_valid(5, 5, 1);
    cycles(14);
    pulse_valid(7, 7, 1);
    cycles(24);
    chk("laststep_ready_cnt", 32'(ready_seen - base), 32'd1);
    expect_digit("laststep_d0", 0, 7'b0010010);

    // reset mid-conversion
    base = ready_seen;
    pulse_valid(4321, 1, 1);
    cycles(7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    cycles(24);
    chk("midrst_ready_cnt", 32'(ready_seen - base), 32'd0);
    expect_digit("midrst_d0", 0, 7'b1000000);
    pulse_valid(14, 2, 1);
    cycles(20);
    expect_digit("recover_d0", 0, 7'b0011001);

    // toggle rise on the commit edge: new sel picks new values
    pulse_valid(57, 3, 1);
    cycles(14);
    @(negedge clk); toggle = 1'b1;
    @(negedge clk); toggle = 1'b0;
    cycles(2);
    expect_digit("simul_d0", 0, 7'b0110000);
    expect_digit("simul_d7", 7, 7'b0101111);

    cycles(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
